receptor_ps2: RTL and testbench
===============================

// Module: receptor_ps2
// PURPOSE
//  Receives PS/2 keyboard frames and presents completed scan codes to the key-filter stage.
//  Inputs are the raw ps2_clk/ps2_data pins; the output is a held scan-code byte on `dato`
//  plus a one-cycle `dato_listo` strobe.
//  The key filter consumes dato[6:0] directly, so `dato` changes only on a valid make/break byte.
//  Handles synchronisation, clock deglitching, 11-bit framing, odd parity, timeout and the F0 break prefix.
// PARAMETERS
//  FILTRO_LEN   4     consecutive equal samples required before the filtered ps2_clk changes level
//  TIMEOUT_CYC  5000  system clocks allowed between ps2_clk falling edges inside a frame (100 us @ 50 MHz)
// PORTS
//  clock       in   1  system clock; all logic is on the rising edge
//  reset       in   1  synchronous, active-high reset
//  ps2_clk     in   1  raw PS/2 clock from the keyboard, asynchronous
//  ps2_data    in   1  raw PS/2 data from the keyboard, asynchronous
//  dato        out  8  last accepted scan code (held until the next accepted byte)
//  dato_listo  out  1  one-cycle pulse when `dato` has just been updated
//  liberada    out  1  1 = current `dato` was preceded by F0 (key release); 0 = make code
//  error_trama out  1  one-cycle pulse on parity, stop-bit or timeout error
// BEHAVIOUR
//  Clock and reset
//   - One clock domain (`clock`). Reset is synchronous and active-high.
//   - Reset values: dato=8'h00, dato_listo=0, liberada=0, error_trama=0.
//   - Reset also clears: FSM to IDLE, bit counter, shift register, break pending, timeout counter.
//   - Filtered ps2_clk resets to 1.
//  Input conditioning
//   - 2-FF synchroniser on each pin.
//   - Filtered clock takes the synced level only after FILTRO_LEN consecutive identical samples.
//   - `flanco` = 1 for exactly one cycle when the filtered clock goes 1->0.
//   - Sync data is sampled on the `flanco` cycle.
//  FSM states: IDLE, DATOS, PARIDAD, PARADA
//   - IDLE: on flanco with data=0 (start bit) -> DATOS, bit count=0.
//     Data=1 on flanco is ignored (stay IDLE).
//   - DATOS: each flanco shifts data in LSB-first. After the 8th bit -> PARIDAD.
//   - PARIDAD: flanco captures the parity bit -> PARADA.
//   - PARADA: flanco -> IDLE. The frame is good iff stop=1 AND (8 data bits + parity) has an odd count of ones.
//  Timeout
//   - Counter clears on every flanco and on IDLE.
//   - In any non-IDLE state, reaching TIMEOUT_CYC-1 -> IDLE plus error_trama pulse.
//   - Partial byte is discarded; dato is unchanged.
//  Good frame, byte handling
//   - Byte == F0: set break pending. dato unchanged, no dato_listo.
//   - Any other byte (including E0):
//     - dato <= byte; liberada <= break pending; break pending <= 0.
//     - dato_listo = 1 on the cycle after the PARADA flanco.
//   - Latency: dato/dato_listo valid exactly 1 clock after the stop-bit flanco cycle.
//  Bad frame
//   - error_trama = 1 for one cycle, with the same timing as dato_listo.
//   - Break pending cleared; dato/liberada unchanged.
//  Other rules
//   - Start bit read as 1 is not an error, just idle noise.
//   - Glitches shorter than FILTRO_LEN clocks on ps2_clk never produce flanco.
//   - dato_listo and error_trama are mutually exclusive.
//   - Reset during a frame aborts it. The remainder of that frame is bits with data possibly 0;
//     a mid-frame resync relies on parity, stop-bit or timeout to reject it.
// TESTING
//  1. Frame for 8'h3C, ps2_clk period 80 us, good parity -> dato=8'h3C, liberada=0, one dato_listo pulse, no error.
//  2. F0 then 3C -> no strobe after F0; after 3C dato=8'h3C, liberada=1, single dato_listo.
//  3. 8'h1C sent with even parity -> error_trama pulse; dato keeps prior value; no dato_listo.
//  4. Stop bit 0 -> error_trama. Also: stop after 5 data bits and idle > TIMEOUT_CYC -> error_trama, FSM IDLE.
//     A following good 8'h3C frame is then received correctly.
//  5. 2-clock low glitches on ps2_clk inside a frame -> ignored; byte 8'h3C received intact.
//  6. reset=1 for 1 cycle after 4 data bits -> all outputs 0 next cycle.
//     After timeout recovery, the next full frame 8'h2B -> dato=8'h2B.

Source files
------------

// File: rtl/receptor_ps2.sv
// PS/2 keyboard receiver: pin sync, clock deglitch, 11-bit framing, odd parity, timeout, F0 break prefix.
// Latency: dato/dato_listo (or error_trama) one clock after the stop-bit flanco; no backpressure, strobe output.
module receptor_ps2 #(
  parameter int FILTRO_LEN  = 4,
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] dato,
  output logic       dato_listo,
  output logic       liberada,
  output logic       error_trama
);

  localparam int FW = $clog2(FILTRO_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, DATOS, PARIDAD, PARADA} estado_t;

  logic          clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
  logic          dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  logic          clk_filt_q, clk_filt_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic          flanco_q, flanco_d;
  estado_t       estado_q, estado_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          brk_q, brk_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]    dato_q, dato_d;
  logic          listo_q, listo_d;
  logic          lib_q, lib_d;
  logic          err_q, err_d;

  always_comb begin
    clk_s1_d   = ps2_clk;
    clk_s2_d   = clk_s1_q;
    dat_s1_d   = ps2_data;
    dat_s2_d   = dat_s1_q;
    clk_filt_d = clk_filt_q;
    filt_cnt_d = filt_cnt_q;
    estado_d   = estado_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    brk_d      = brk_q;
    dato_d     = dato_q;
    lib_d      = lib_q;
    listo_d    = 1'b0;
    err_d      = 1'b0;

    // filt_cnt counts consecutive samples that disagree with the filtered level
    if (clk_s2_q == clk_filt_q) begin
      filt_cnt_d = '0;
    end else if (filt_cnt_q == FW'(FILTRO_LEN - 1)) begin
      clk_filt_d = clk_s2_q;
      filt_cnt_d = '0;
    end else begin
      filt_cnt_d = filt_cnt_q + FW'(1);
    end
    flanco_d = clk_filt_q & ~clk_filt_d;

    to_cnt_d = (flanco_q || estado_q == IDLE) ? '0 : to_cnt_q + TW'(1);

    case (estado_q)
      IDLE: begin
        if (flanco_q && !dat_s2_q) begin
          estado_d  = DATOS;
          bit_cnt_d = '0;
        end
      end
      DATOS: begin
        if (flanco_q) begin
          shift_d   = {dat_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) estado_d = PARIDAD;
        end
      end
      PARIDAD: begin
        if (flanco_q) begin
          par_d    = dat_s2_q;
          estado_d = PARADA;
        end
      end
      PARADA: begin
        if (flanco_q) begin
          estado_d = IDLE;
          if (dat_s2_q && ^{shift_q, par_q}) begin
            if (shift_q == 8'hF0) begin
              brk_d = 1'b1;
            end else begin
              dato_d  = shift_q;
              lib_d   = brk_q;
              brk_d   = 1'b0;
              listo_d = 1'b1;
            end
          end else begin
            err_d = 1'b1;
            brk_d = 1'b0;
          end
        end
      end
      default: estado_d = IDLE;
    endcase

    // a stalled frame is dropped; dato is left untouched
    if (!flanco_q && estado_q != IDLE && to_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
      estado_d = IDLE;
      err_d    = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      clk_filt_q <= 1'b1;
      filt_cnt_q <= '0;
      flanco_q   <= 1'b0;
      estado_q   <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      brk_q      <= 1'b0;
      to_cnt_q   <= '0;
      dato_q     <= '0;
      listo_q    <= 1'b0;
      lib_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      clk_s1_q   <= clk_s1_d;
      clk_s2_q   <= clk_s2_d;
      dat_s1_q   <= dat_s1_d;
      dat_s2_q   <= dat_s2_d;
      clk_filt_q <= clk_filt_d;
      filt_cnt_q <= filt_cnt_d;
      flanco_q   <= flanco_d;
      estado_q   <= estado_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      brk_q      <= brk_d;
      to_cnt_q   <= to_cnt_d;
      dato_q     <= dato_d;
      listo_q    <= listo_d;
      lib_q      <= lib_d;
      err_q      <= err_d;
    end
  end

  assign dato        = dato_q;
  assign dato_listo  = listo_q;
  assign liberada    = lib_q;
  assign error_trama = err_q;

endmodule

// File: tb/tb_receptor_ps2.sv
// Bench for receptor_ps2: directed and random PS/2 frames against a bit-stream reference model.
module tb_receptor_ps2;

  localparam int TIMEOUT = 5000;
  localparam int H       = 30;  // ps2_clk half period in system clocks (scaled down)

  logic       clock = 1'b0;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] dato;
  logic       dato_listo;
  logic       liberada;
  logic       error_trama;

  receptor_ps2 #(.FILTRO_LEN(4), .TIMEOUT_CYC(TIMEOUT)) dut (
    .clock       (clock),
    .reset       (reset),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .dato        (dato),
    .dato_listo  (dato_listo),
    .liberada    (liberada),
    .error_trama (error_trama)
  );

  always #10 clock = ~clock;

  int tests = 0;
  int fails = 0;

  int listo_seen = 0;
  int err_seen   = 0;
  int excl_viol  = 0;

  always @(negedge clock) begin
    if (dato_listo) listo_seen++;
    if (error_trama) err_seen++;
    if (dato_listo && error_trama) excl_viol++;
  end

  // Reference model: consumes the bit seen at each ps2_clk falling edge
  logic       mq[$];
  logic       m_in;
  logic       m_brk;
  logic [7:0] exp_dato;
  logic       exp_lib;
  int         exp_listo = 0;
  int         exp_err   = 0;

  task automatic model_reset();
    m_in     = 1'b0;
    m_brk    = 1'b0;
    exp_dato = 8'h00;
    exp_lib  = 1'b0;
    mq.delete();
  endtask

  task automatic model_bit(input logic b);
    logic [7:0] by;
    int         ones;
    by   = 8'h00;
    ones = 0;
    if (!m_in) begin
      if (b == 1'b0) begin
        m_in = 1'b1;
        mq.delete();
      end
    end else begin
      mq.push_back(b);
      if (mq.size() == 10) begin
        for (int i = 0; i < 8; i++) begin
          by[i] = mq[i];
          ones += int'(mq[i]);
        end
        ones += int'(mq[8]);
        if (mq[9] == 1'b1 && (ones % 2) == 1) begin
          if (by == 8'hF0) begin
            m_brk = 1'b1;
          end else begin
            exp_dato = by;
            exp_lib  = m_brk;
            m_brk    = 1'b0;
            exp_listo++;
          end
        end else begin
          exp_err++;
          m_brk = 1'b0;
        end
        m_in = 1'b0;
      end
    end
  endtask

  task automatic model_timeout();
    if (m_in) begin
      exp_err++;
      m_in = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_listo"}, listo_seen, exp_listo);
    chk({tag, "_err"}, err_seen, exp_err);
    chk({tag, "_dato"}, {24'h0, dato}, {24'h0, exp_dato});
    chk({tag, "_lib"}, {31'h0, liberada}, {31'h0, exp_lib});
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_bit(input logic b, input logic glitch);
    ps2_data = b;
    if (glitch) begin
      idle(12);
      ps2_clk = 1'b0;
      idle(2);
      ps2_clk = 1'b1;
      idle(H - 14);
    end else begin
      idle(H);
    end
    ps2_clk = 1'b0;
    model_bit(b);
    idle(H);
    ps2_clk = 1'b1;
  endtask

  // Sends bits lo..hi of the 11-bit frame: start, 8 data LSB first, parity, stop
  task automatic send_range(input logic [7:0] b, input logic par_ok, input logic stop,
                            input logic glitch, input int lo, input int hi);
    logic [10:0] fr;
    fr = {stop, (par_ok ? ~^b : ^b), b, 1'b0};
    for (int i = lo; i <= hi; i++) send_bit(fr[i], glitch);
    idle(H);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par_ok, input logic stop,
                            input logic glitch);
    send_range(b, par_ok, stop, glitch, 0, 10);
  endtask

  initial begin
    logic [7:0] rb;
    int         r;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    reset    = 1'b1;
    model_reset();
    idle(3);
    chk("rst_dato", {24'h0, dato}, 32'h0);
    chk("rst_listo", {31'h0, dato_listo}, 32'h0);
    chk("rst_lib", {31'h0, liberada}, 32'h0);
    chk("rst_err", {31'h0, error_trama}, 32'h0);
    reset = 1'b0;
    idle(10);

    send_frame(8'h3C, 1'b1, 1'b1, 1'b0);
    check_state("t1_make");

    send_frame(8'hF0, 1'b1, 1'b1, 1'b0);
    check_state("t2_f0");
    send_frame(8'h3C, 1'b1, 1'b1, 1'b0);
    check_state("t2_break");

    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    check_state("t3_parity");

    send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
    check_state("t4_stop");
    send_range(8'h55, 1'b1, 1'b1, 1'b0, 0, 5);
    idle(TIMEOUT + 100);
    model_timeout();
    check_state("t4_timeout");
    send_frame(8'h3C, 1'b1, 1'b1, 1'b0);
    check_state("t4_recover");

    send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
    check_state("t5_glitch");

    rb = 8'($urandom_range(0, 255));
    send_range(rb, 1'b1, 1'b1, 1'b0, 0, 4);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    model_reset();
    chk("t6_rst_dato", {24'h0, dato}, 32'h0);
    chk("t6_rst_listo", {31'h0, dato_listo}, 32'h0);
    chk("t6_rst_lib", {31'h0, liberada}, 32'h0);
    chk("t6_rst_err", {31'h0, error_trama}, 32'h0);
    send_range(rb, 1'b1, 1'b1, 1'b0, 5, 10);
    idle(TIMEOUT + 100);
    model_timeout();
    check_state("t6_resync");
    send_frame(8'h2B, 1'b1, 1'b1, 1'b0);
    check_state("t6_2b");

    for (int k = 0; k < 12; k++) begin
      rb = 8'($urandom_range(0, 255));
      r  = int'($urandom_range(0, 9));
      if (r < 3) send_frame(8'hF0, 1'b1, 1'b1, 1'b0);
      send_frame(rb, r != 9, r != 8, 1'($urandom_range(0, 1)));
      check_state($sformatf("rnd%0d", k));
    end

    chk("exclusive", excl_viol, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
